conv_mac_0: RTL and testbench

- Consumer stage directly downstream of the weight store: takes the registered 288-entry weight bus once it is valid and applies it to a stream of 3x3 input windows.
- Weights form 32 output channels x 9 taps. Each window is processed serially over 9 taps, with 32 parallel MAC lanes.
- Each window produces one 32-channel output word: rescaled, saturated, optional ReLU. The word is handed downstream over a valid/ready handshake.

---
 rtl/conv_mac_0.sv | 176 +++++++++++++++++
 tb/tb_conv_mac_0.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_0.sv
// conv_mac_0: 3x3 convolution MAC stage, 32 output channels x 9 taps.
// Takes the 288-entry weight bus from the weight store. For each accepted
// 3x3 window it accumulates one tap per cycle across 32 parallel lanes. The
// result is rescaled (>>> FRAC), saturated, optionally passed through ReLU,
// and then held on a valid/ready output.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   w_valid, w_q        weight bus valid and weights (ch*9+tap, `DATA_LEN each)
//   in_valid/in_ready   window handshake, in_data = 9 taps (row*3+col)
//   out_valid/out_ready result handshake, out_data = 32 channels

`ifndef DATA_LEN
`define DATA_LEN 16
`endif

// One output channel: accumulator plus rescale/saturate/ReLU of the held sum.
module conv_mac_0_lane #(
    parameter int DL   = 16,
    parameter int FRAC = 8,
    parameter int RELU = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DL-1:0] w,
    input  logic [DL-1:0] x,
    output logic [DL-1:0] y
);
    localparam int AW = 2*DL + 4;
    // Output range limits, sign-extended to accumulator width
    localparam logic signed [AW-1:0] MAXV = {{(AW-DL+1){1'b0}}, {(DL-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DL+1){1'b1}}, {(DL-1){1'b0}}};

    logic signed [2*DL-1:0] prod;
    logic signed [AW-1:0]   acc_q, acc_d, r;

    always_comb begin
        prod  = $signed(w) * $signed(x);
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + AW'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    always_comb begin
        r = acc_q >>> FRAC;
        if (r > MAXV)
            y = {1'b0, {(DL-1){1'b1}}};
        else if (r < MINV)
            y = {1'b1, {(DL-1){1'b0}}};
        else
            y = r[DL-1:0];
        if (RELU != 0 && r[AW-1])
            y = '0;
    end
endmodule

module conv_mac_0 #(
    parameter int FRAC = 8,
    parameter int RELU = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_valid,
    input  logic [288*`DATA_LEN-1:0]  w_q,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [9*`DATA_LEN-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [32*`DATA_LEN-1:0]   out_data
);
    localparam int DL   = `DATA_LEN;
    localparam int NCH  = 32;
    localparam int NTAP = 9;

    typedef enum logic [1:0] {IDLE, MAC, SAT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [3:0]          tap_q, tap_d;
    logic [NTAP*DL-1:0]  win_q, win_d;
    logic [NCH*DL-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [NCH*DL-1:0]   sat_y;
    logic [DL-1:0]       x_tap;
    logic                accept, mac_en, acc_clr;

    // Gated by rst so the reset cycle itself never advertises ready
    assign in_ready  = (state_q == IDLE) && w_valid && !rst;
    assign accept    = in_ready && in_valid;
    assign mac_en    = (state_q == MAC) && w_valid;
    // Accumulators clear on a new window and on a weight-loss abort
    assign acc_clr   = accept || ((state_q == MAC) && !w_valid);
    assign x_tap     = win_q[int'(tap_q)*DL +: DL];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        conv_mac_0_lane #(.DL(DL), .FRAC(FRAC), .RELU(RELU)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (acc_clr),
            .en  (mac_en),
            .w   (w_q[(c*NTAP + int'(tap_q))*DL +: DL]),
            .x   (x_tap),
            .y   (sat_y[c*DL +: DL])
        );
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        win_d       = win_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    win_d   = in_data;
                    tap_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (!w_valid) begin
                    tap_d   = '0;
                    state_d = IDLE;
                end else if (tap_q == 4'(NTAP-1)) begin
                    tap_d   = '0;
                    state_d = SAT;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            SAT: begin
                out_data_d  = sat_y;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                // Held result survives w_valid dropping; only out_ready releases it
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            win_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            win_q       <= win_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_conv_mac_0.sv
// Directed bench for conv_mac_0 with `DATA_LEN=16, FRAC=8. Two instances share
// all inputs: u_relu (RELU=1) and u_lin (RELU=0).

`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_conv_mac_0;
    localparam int DL = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               w_valid;
    logic [288*DL-1:0]  w_q;
    logic               in_valid;
    logic [9*DL-1:0]    in_data;
    logic               out_ready;
    logic               in_ready_r, in_ready_l;
    logic               out_valid_r, out_valid_l;
    logic [32*DL-1:0]   out_data_r, out_data_l;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_mac_0 #(.FRAC(8), .RELU(1)) u_relu (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_q(w_q),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r)
    );

    conv_mac_0 #(.FRAC(8), .RELU(0)) u_lin (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_q(w_q),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l)
    );

    // chsep: weight[c*9+0] = c*wv, other weights 0; else every weight = wv.
    // Expected lane c = e_relu/e_lin + c*e_step.
    typedef struct {
        string       nm;
        bit          chsep;
        logic [15:0] wv, t0, tr;
        logic [15:0] e_relu, e_lin, e_step;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] expv(input vec_t v, input bit relu);
        logic [511:0] e;
        e = '0;
        for (int c = 0; c < 32; c++)
            e[c*16 +: 16] = (relu ? v.e_relu : v.e_lin) + 16'(c) * v.e_step;
        return e;
    endfunction

    task automatic load(input vec_t v);
        for (int ch = 0; ch < 32; ch++)
            for (int t = 0; t < 9; t++)
                if (v.chsep)
                    w_q[(ch*9+t)*16 +: 16] = (t == 0) ? 16'(ch) * v.wv : 16'h0000;
                else
                    w_q[(ch*9+t)*16 +: 16] = v.wv;
        for (int t = 0; t < 9; t++)
            in_data[t*16 +: 16] = (t == 0) ? v.t0 : v.tr;
    endtask

    // Called #1 after an edge. Accepts one window, checks latency and both
    // results; with take=1 also drains it, else leaves the DUTs in HOLD.
    task automatic run_vec(input vec_t v, input bit take);
        int k;
        load(v);
        w_valid  = 1'b1;
        in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready_r && k < 5) begin
            @(posedge clk); #1; k++;
        end
        chk({v.nm, "_ready"}, 512'(in_ready_r), 512'(1));
        @(posedge clk); #1;          // accept edge T
        in_valid = 1'b0;
        k = 0;
        while (!out_valid_r && k < 20) begin
            if (in_ready_r) begin
                n_bad++;
                $display("FAIL %s in_ready during busy", v.nm);
            end
            @(posedge clk); #1; k++;
        end
        chk({v.nm, "_latency"}, 512'(k), 512'(10));
        chk({v.nm, "_relu"}, out_data_r, expv(v, 1'b1));
        chk({v.nm, "_lin"}, out_data_l, expv(v, 1'b0));
        if (take) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({v.nm, "_drop"}, 512'(out_valid_r), 512'(0));
        end
    endtask

    initial begin
        logic [511:0] held;
        int k;
        bit seen;

        tv[0] = '{"basic",  1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0900, 16'h0900, 16'h0000};
        tv[1] = '{"chsep",  1'b1, 16'h0100, 16'h0200, 16'h7FFF, 16'h0000, 16'h0000, 16'h0200};
        tv[2] = '{"satpos", 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000};
        tv[3] = '{"neg",    1'b0, 16'hFF00, 16'h0100, 16'h0100, 16'h0000, 16'hF700, 16'h0000};
        tv[4] = '{"satneg", 1'b0, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000};
        tv[5] = '{"frac",   1'b0, 16'h0180, 16'h0040, 16'h0040, 16'h0360, 16'h0360, 16'h0000};
        tv[6] = '{"trunc",  1'b0, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
        tv[7] = '{"ashr",   1'b0, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000};

        rst = 1'b1; w_valid = 1'b1; w_q = '0; in_valid = 1'b1; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 512'(out_valid_r), 512'(0));
        chk("rst_in_ready", 512'(in_ready_r), 512'(0));
        chk("rst_out_data", out_data_r, '0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_vec(tv[i], 1'b1);

        // Backpressure: hold result 5 cycles while a window is offered
        run_vec(tv[0], 1'b0);
        held = out_data_r;
        load(tv[2]);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_data", out_data_r, held);
            chk("bp_state", 512'({out_valid_r, in_ready_r}), 512'(2'b10));
        end
        load(tv[0]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_drop", 512'({out_valid_r, in_ready_r}), 512'(2'b01));
        @(posedge clk); #1;          // accepted one cycle after the drop
        in_valid = 1'b0;
        k = 0;
        while (!out_valid_r && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk("bp_latency", 512'(k), 512'(10));
        chk("bp_result", out_data_r, expv(tv[0], 1'b1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Weight gating: no accept while w_valid is low
        load(tv[0]);
        w_valid = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("gate_ready", 512'(in_ready_r), 512'(0));
            @(posedge clk); #1;
        end
        chk("gate_no_out", 512'(out_valid_r), 512'(0));

        // Abort: w_valid drops before the 4th MAC edge
        w_valid = 1'b1;
        @(posedge clk); #1;          // accept edge
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        w_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid_r) seen = 1'b1;
        end
        chk("abort_no_out", 512'(seen), 512'(0));
        w_valid = 1'b1;
        #1;
        chk("abort_idle", 512'(in_ready_r), 512'(1));
        run_vec(tv[0], 1'b1);

        // Reset during MAC
        load(tv[2]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmac_state", 512'({out_valid_r, in_ready_r}), 512'(0));
        chk("rstmac_data", out_data_r, '0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid_r) seen = 1'b1;
        end
        chk("rstmac_no_out", 512'(seen), 512'(0));
        run_vec(tv[0], 1'b1);

        // Reset during HOLD
        run_vec(tv[5], 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rsthold_state", 512'({out_valid_r, in_ready_r}), 512'(0));
        chk("rsthold_data", out_data_r, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(tv[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
